// File: rtl/board_move_if.sv
// Request/response bundle between the direction decoder, the move engine and the tile spawner.
// Handshake: start is a request taken only while the engine is idle (busy low); each accepted
// start yields exactly one done pulse, and board_out/moved/score_delta are valid from done on.
interface board_move_if #(
    parameter int TILE_W  = 21,
    parameter int SCORE_W = 24
);
    logic                  start;
    logic [1:0]            dir;
    logic [16*TILE_W-1:0]  board_in;
    logic                  busy;
    logic                  done;
    logic                  moved;
    logic [16*TILE_W-1:0]  board_out;
    logic [SCORE_W-1:0]    score_delta;

    modport master (
        output start, dir, board_in,
        input  busy, done, moved, board_out, score_delta
    );

    modport slave (
        input  start, dir, board_in,
        output busy, done, moved, board_out, score_delta
    );
endinterface

// File: rtl/board_move_engine.sv
// One 2048 move on a 4x4 board: one line per PROC cycle, fixed 5-cycle latency to done.
// Outputs are registered and held until the next accepted start.
module board_move_engine #(
    parameter int TILE_W  = 21,
    parameter int SCORE_W = 24
) (
    input  logic          clk,
    input  logic          rst,
    board_move_if.slave   bus,
    output logic [2:0]    dbg_state
);
    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [3:0]       line_t;
    typedef tile_t [15:0]      board_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PROC0 = 3'd1,
        PROC1 = 3'd2,
        PROC2 = 3'd3,
        PROC3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           dir_q, dir_d;
    board_t               work_q, work_d;
    board_t               orig_q, orig_d;
    logic [SCORE_W-1:0]   acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 moved_q, moved_d;
    board_t               board_out_q, board_out_d;
    logic [SCORE_W-1:0]   score_q, score_d;

    logic [1:0]           line_k;
    line_t                line_in;
    line_t                line_out;
    logic [SCORE_W-1:0]   line_sum;
    board_t               work_upd;

    // Element j of line k; element 0 sits at the edge the tiles move toward.
    // Tile (r,c) lives at index 4r+c, which is just {r,c}.
    function automatic logic [3:0] tile_idx(input logic [1:0] d, input logic [1:0] k,
                                            input logic [1:0] j);
        logic [1:0] r;
        logic [1:0] c;
        case (d)
            2'd0:    begin r = j;  c = k;  end
            2'd1:    begin r = ~j; c = k;  end
            2'd2:    begin r = k;  c = j;  end
            default: begin r = k;  c = ~j; end
        endcase
        return {r, c};
    endfunction

    function automatic line_t compact(input line_t in);
        line_t      res;
        logic [2:0] n;
        res = '0;
        n   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (in[i] != '0) begin
                res[n[1:0]] = in[i];
                n           = n + 3'd1;
            end
        end
        return res;
    endfunction

    // Compact, merge each equal pair once (tiles with the top bit set never merge), compact again.
    function automatic void slide_line(input line_t in, output line_t out,
                                       output logic [SCORE_W-1:0] sum);
        line_t c1;
        logic  skip;
        c1   = compact(in);
        sum  = '0;
        skip = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c1[i] != '0 && c1[i] == c1[i+1] && !c1[i][TILE_W-1]) begin
                c1[i]   = c1[i] << 1;
                c1[i+1] = '0;
                sum     = sum + SCORE_W'(c1[i]);
                skip    = 1'b1;
            end
        end
        out = compact(c1);
    endfunction

    always_comb begin
        line_k = 2'd0;
        case (state_q)
            PROC1:   line_k = 2'd1;
            PROC2:   line_k = 2'd2;
            PROC3:   line_k = 2'd3;
            default: line_k = 2'd0;
        endcase
    end

    always_comb begin
        line_in  = '0;
        line_out = '0;
        line_sum = '0;
        work_upd = work_q;
        for (int j = 0; j < 4; j++) begin
            line_in[j] = work_q[tile_idx(dir_q, line_k, 2'(j))];
        end
        slide_line(line_in, line_out, line_sum);
        for (int j = 0; j < 4; j++) begin
            work_upd[tile_idx(dir_q, line_k, 2'(j))] = line_out[j];
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        work_d      = work_q;
        orig_d      = orig_q;
        acc_d       = acc_q;
        moved_d     = moved_q;
        board_out_d = board_out_q;
        score_d     = score_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.board_in;
                    orig_d  = bus.board_in;
                    dir_d   = bus.dir;
                    acc_d   = '0;
                    state_d = PROC0;
                end
            end
            PROC0, PROC1, PROC2: begin
                work_d  = work_upd;
                acc_d   = acc_q + line_sum;
                state_d = state_t'(state_q + 3'd1);
            end
            PROC3: begin
                // Results are registered here so they appear together with done.
                work_d      = work_upd;
                acc_d       = acc_q + line_sum;
                board_out_d = work_upd;
                moved_d     = (work_upd != orig_q);
                score_d     = acc_q + line_sum;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= 2'd0;
            work_q      <= '0;
            orig_q      <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            moved_q     <= 1'b0;
            board_out_q <= '0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            work_q      <= work_d;
            orig_q      <= orig_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            moved_q     <= moved_d;
            board_out_q <= board_out_d;
            score_q     <= score_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.moved       = moved_q;
    assign bus.board_out   = board_out_q;
    assign bus.score_delta = score_q;
    assign dbg_state       = state_q;
endmodule
